// File: rtl/data_mem_arbiter.sv
// Data RAM arbiter: round-robin between CPU and host loader ports,
// one access at a time, with an optional host-exclusive lock.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   cpu_*            CPU request/grant/read-data port
//   host_*           host/UART loader port, same shape as cpu_*
//   host_lock        host exclusive ownership, blocks new CPU grants
//   ram_we/addr/     single-port synchronous RAM interface
//   wdata/rdata      (read data valid one cycle after the address)
//   conflict_clr     synchronous clear of conflict_cnt
//   conflict_cnt     saturating count of IDLE cycles with both requests
//   busy             high whenever an access is in flight
module data_mem_arbiter #(
    parameter int DATA_AW = 14,
    parameter int DW      = 24
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [DATA_AW-1:0] cpu_addr,
    input  logic [DW-1:0]      cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [DW-1:0]      cpu_rdata,

    input  logic               host_req,
    input  logic               host_we,
    input  logic [DATA_AW-1:0] host_addr,
    input  logic [DW-1:0]      host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [DW-1:0]      host_rdata,

    input  logic               host_lock,

    output logic               ram_we,
    output logic [DATA_AW-1:0] ram_addr,
    output logic [DW-1:0]      ram_wdata,
    input  logic [DW-1:0]      ram_rdata,

    input  logic               conflict_clr,
    output logic [15:0]        conflict_cnt,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        ACC_CPU,
        ACC_HOST,
        RD_CPU,
        RD_HOST
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          last_host_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic [15:0]   conflict_q;
    logic [15:0]   conflict_d;

    logic cpu_elig;
    logic both_elig;
    logic idle_conflict;

    assign cpu_elig      = cpu_req & ~host_lock;
    assign both_elig     = cpu_elig & host_req;
    assign idle_conflict = (state_q == IDLE) & cpu_req & host_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_host_q  <= 1'b1;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            conflict_q   <= '0;
        end else begin
            state_q    <= state_d;
            // Written every cycle so the counter always tracks conflict_d.
            conflict_q <= conflict_d;
            if (state_q == ACC_CPU) begin
                last_host_q <= 1'b0;
            end
            if (state_q == ACC_HOST) begin
                last_host_q <= 1'b1;
            end
            if (state_q == RD_CPU) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (state_q == RD_HOST) begin
                host_rdata_q <= ram_rdata;
            end
        end
    end

    // Arbitration terms are mutually exclusive; a locked host request
    // falls into the host-only term because the CPU is not eligible.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    both_elig: begin
                        state_d = last_host_q ? ACC_CPU : ACC_HOST;
                    end
                    cpu_elig & ~host_req: begin
                        state_d = ACC_CPU;
                    end
                    host_req & ~cpu_elig: begin
                        state_d = ACC_HOST;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            ACC_CPU: begin
                state_d = cpu_we ? IDLE : RD_CPU;
            end
            ACC_HOST: begin
                state_d = host_we ? IDLE : RD_HOST;
            end
            RD_CPU: begin
                state_d = IDLE;
            end
            RD_HOST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_gnt     = 1'b0;
        host_gnt    = 1'b0;
        cpu_rvalid  = 1'b0;
        host_rvalid = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        cpu_rdata   = cpu_rdata_q;
        host_rdata  = host_rdata_q;
        unique case (state_q)
            ACC_CPU: begin
                cpu_gnt   = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            ACC_HOST: begin
                host_gnt  = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
            end
            RD_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = ram_rdata;
            end
            RD_HOST: begin
                host_rvalid = 1'b1;
                host_rdata  = ram_rdata;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        conflict_d = conflict_q;
        if (conflict_clr) begin
            conflict_d = '0;
        end else if (idle_conflict && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter.
// Inputs change and outputs are sampled on the falling edge.
module tb_data_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          host_lock;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          conflict_clr;
    logic [15:0]   conflict_cnt;
    logic          busy;

    logic [DW-1:0] mem [0:255];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[7:0]];
    end

    data_mem_arbiter #(.DATA_AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .host_lock    (host_lock),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .conflict_clr (conflict_clr),
        .conflict_cnt (conflict_cnt),
        .busy         (busy)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int hg;
        int cg;
        int seen;

        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
        end
        rst          = 1'b1;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;
        host_lock    = 1'b0;
        conflict_clr = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gnt", {cpu_gnt, host_gnt}, 0);
        check("rst_rv", {cpu_rvalid, host_rvalid}, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_cnt", conflict_cnt, 0);
        check("rst_rdata", {cpu_rdata, host_rdata}, 0);

        // CPU write, request present on the first edge after release
        rst       = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 14'h0010;
        cpu_wdata = 24'h00ABCD;
        @(negedge clk);
        check("wr_gnt", cpu_gnt, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 32'h10);
        check("wr_ram_wdata", ram_wdata, 32'hABCD);
        check("wr_host_gnt", host_gnt, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("wr_idle", busy, 0);
        check("wr_gnt_off", cpu_gnt, 0);
        check("wr_ram_off", {ram_we, ram_addr, ram_wdata}, 0);

        // CPU read back
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        @(negedge clk);
        check("rd_gnt", cpu_gnt, 1);
        check("rd_ram_we", ram_we, 0);
        check("rd_ram_addr", ram_addr, 32'h10);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", cpu_rvalid, 1);
        check("rd_gnt_off", cpu_gnt, 0);
        check("rd_rdata", cpu_rdata, 32'hABCD);
        @(negedge clk);
        check("rd_rvalid_off", cpu_rvalid, 0);
        check("rd_hold", cpu_rdata, 32'hABCD);
        check("rd_idle", busy, 0);

        // Reset again so the pointer is back at HOST
        rst = 1'b1;
        @(negedge clk);
        check("rst2_rdata", cpu_rdata, 0);
        rst = 1'b0;

        // Continuous conflict: CPU, HOST, CPU, HOST
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 14'h0001;
        cpu_wdata  = 24'h000111;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 14'h0002;
        host_wdata = 24'h000222;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rr_cpu%0d", i), cpu_gnt, (i % 4) == 0);
            check($sformatf("rr_host%0d", i), host_gnt, (i % 4) == 2);
            check($sformatf("rr_cnt%0d", i), conflict_cnt, i / 2 + 1);
        end
        check("rr_mem1", mem[1], 32'h111);
        check("rr_mem2", mem[2], 32'h222);

        // Host lock with both requests held
        host_lock = 1'b1;
        hg = 0;
        cg = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hg += int'(host_gnt);
            cg += int'(cpu_gnt);
        end
        check("lock_host_gnts", hg, 8);
        check("lock_cpu_gnts", cg, 0);
        check("lock_cnt", conflict_cnt, 12);
        host_lock = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_gnt && seen == 0) begin
                seen = i + 1;
            end
        end
        check("unlock_cpu_gnt", seen != 0, 1);
        cpu_req  = 1'b0;
        host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("unlock_idle", busy, 0);

        // Reset during RD_HOST
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 14'h0010;
        @(negedge clk);
        check("rsth_gnt", host_gnt, 1);
        host_req = 1'b0;
        @(posedge clk);
        #1;
        check("rsth_in_rd", busy, 1);
        rst = 1'b1;
        #1;
        check("rsth_rvalid", host_rvalid, 0);
        check("rsth_busy", busy, 0);
        check("rsth_rdata", host_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen += int'(host_rvalid) + int'(host_gnt)
                  + int'(cpu_rvalid) + int'(cpu_gnt) + int'(busy);
        end
        check("rsth_no_pulse", seen, 0);

        // Saturation and clear
        force dut.conflict_q = 16'hFFFE;
        @(negedge clk);
        @(negedge clk);
        release dut.conflict_q;
        @(negedge clk);
        check("sat_preload", conflict_cnt, 32'hFFFE);
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        host_req = 1'b1;
        host_we  = 1'b1;
        @(negedge clk);
        check("sat_1", conflict_cnt, 32'hFFFF);
        @(negedge clk);
        @(negedge clk);
        check("sat_2", conflict_cnt, 32'hFFFF);
        @(negedge clk);
        @(negedge clk);
        check("sat_3", conflict_cnt, 32'hFFFF);
        @(negedge clk);
        conflict_clr = 1'b1;
        @(negedge clk);
        check("clr_cnt", conflict_cnt, 0);
        conflict_clr = 1'b0;
        cpu_req      = 1'b0;
        host_req     = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_AW, default 14, meaning the data RAM word address width.
REQ-002 The block SHALL have parameter DW, default 24, meaning the data word width.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; cpu_we/addr/wdata held stable until cpu_gnt.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  DATA_AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access performed this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DW  CPU read data.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: host/UART loader port, same directions, widths and meanings as the CPU port.
- host_lock  in  1  host exclusive ownership; the CPU is never granted while it is high.
- ram_we  out  1  RAM write enable.
- ram_addr  out  DATA_AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, synchronous, valid 1 cycle after address.
- conflict_clr  in  1  synchronous clear of conflict_cnt.
- conflict_cnt  out  16  saturating count of IDLE cycles with both requests high.
- busy  out  1  high whenever state != IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, ACC_CPU, ACC_HOST, RD_CPU and RD_HOST.
REQ-005 In IDLE with no eligible request, the FSM SHALL stay in IDLE.
REQ-006 A CPU request SHALL be eligible only when cpu_req=1 and host_lock=0.
REQ-007 In IDLE with a single eligible requester, the FSM SHALL go to that requester's ACC state next cycle.
REQ-008 In IDLE with both eligible, round-robin SHALL apply: the requester not served last wins; the last-served pointer SHALL reset to HOST, so the CPU wins the first conflict.
REQ-009 In IDLE with host_req=1 and host_lock=1, the host SHALL win regardless of the pointer.
REQ-010 In ACC_x:
- ram_addr/ram_wdata/ram_we SHALL be driven combinationally from port x inputs.
- gnt_x SHALL be 1 for exactly that cycle.
- the last-served pointer SHALL be updated to x.
REQ-011 From ACC_x, the FSM SHALL go to IDLE if we_x=1, and to RD_x if we_x=0.
REQ-012 In RD_x, rvalid_x SHALL be 1 for one cycle, rdata_x SHALL equal ram_rdata, and the next state SHALL be IDLE.
REQ-013 rdata_x SHALL hold its last value outside RD_x.
REQ-014 Latency: request sampled in IDLE at cycle N, gnt at N+1, rvalid at N+2; the next arbitration SHALL occur at N+2 for writes and N+3 for reads.
REQ-015 Outside ACC states, ram_we SHALL be 0, and ram_addr and ram_wdata SHALL be 0.
REQ-016 ram_we SHALL never be asserted for a CPU access while host_lock was high at the IDLE decision.
REQ-017 Deassertion of a request after IDLE has selected it SHALL NOT abort the access; the requester is responsible for holding its signals.
REQ-018 host_lock rising during ACC_CPU or RD_CPU SHALL let that CPU transaction complete; it blocks only subsequent CPU grants.
REQ-019 conflict_cnt SHALL increment by 1 in each IDLE cycle where cpu_req=1 and host_req=1 (regardless of host_lock) and SHALL saturate at 16'hFFFF.
REQ-020 conflict_clr SHALL take priority over increment and SHALL set conflict_cnt to 0 next cycle.
REQ-021 gnt_x and rvalid_x SHALL never be asserted for both ports in the same cycle.

Reset
REQ-022 Reset assertion SHALL immediately force:
- state to IDLE;
- cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, ram_we and busy to 0;
- cpu_rdata, host_rdata, ram_addr, ram_wdata and conflict_cnt to 0;
- the last-served pointer to HOST.
REQ-023 A transaction in progress at reset SHALL be dropped with no gnt or rvalid pulse after reset release.
REQ-024 After reset release, the first arbitration SHALL occur on the first rising edge with rst low.

Verification
REQ-025 The bench SHALL cover a CPU write: cpu_req=1, we=1, addr=0x0010, wdata=0x00ABCD -> ram_we=1 and cpu_gnt=1 in the same cycle, 1 cycle after the request; back in IDLE the following cycle.
REQ-026 The bench SHALL cover a CPU read of 0x0010 after that write -> cpu_gnt at N+1, cpu_rvalid at N+2, cpu_rdata=0x00ABCD.
REQ-027 The bench SHALL cover continuous simultaneous requests from reset -> grant order CPU, HOST, CPU, HOST; conflict_cnt increments once per IDLE conflict cycle.
REQ-028 The bench SHALL cover host_lock=1 with both requests held for 8 transactions -> 8 host grants and 0 cpu_gnt; cpu_gnt follows within 3 cycles of lock release.
REQ-029 The bench SHALL cover rst asserted during RD_HOST -> host_rvalid stays 0, busy=0 immediately, and no pulse appears after release.
REQ-030 The bench SHALL cover conflict_cnt preloaded to 0xFFFE plus 3 conflict cycles -> value 0xFFFF; conflict_clr with a concurrent conflict -> value 0.
